// File: rtl/led_shift_sequencer.sv
// LED shift sequencer: single-clock prescaler generating a step enable and a
// run/pause/idle FSM driving rotate, bounce and fill patterns onto the LEDs.
module led_shift_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int N_LED    = 8,
  parameter int CW       = 26
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led,
  output logic             step_tick,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
  typedef enum logic [1:0] {M_ROR = 2'b00, M_ROL = 2'b01, M_BOUNCE = 2'b10, M_FILL = 2'b11} mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_left_q, dir_left_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    limit;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= M_ROR;
      led_q      <= '0;
      cnt_q      <= CW'(1);
      dir_left_q <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    led_d      = led_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    tick_d     = 1'b0;
    limit      = CW'(TICK_DIV) >> speed;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          mode_d  = mode_t'(mode);
          cnt_d   = CW'(1);
          case (mode_t'(mode))
            M_ROL:   led_d = N_LED'(1);
            M_FILL:  led_d = '0;
            default: led_d = {1'b1, {(N_LED-1){1'b0}}};
          endcase
          if (mode_t'(mode) == M_BOUNCE)
            dir_left_d = 1'b0;
        end
      end

      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          led_d   = '0;
          cnt_d   = CW'(1);
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (cnt_q >= limit) begin
          // >= so a speed increase past the current count steps immediately
          cnt_d  = CW'(1);
          tick_d = 1'b1;
          case (mode_q)
            M_ROR:  led_d = {led_q[0], led_q[N_LED-1:1]};
            M_ROL:  led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
            M_BOUNCE: begin
              if (!dir_left_q && led_q[0]) begin
                dir_left_d = 1'b1;
                led_d      = led_q << 1;
              end else if (dir_left_q && led_q[N_LED-1]) begin
                dir_left_d = 1'b0;
                led_d      = led_q >> 1;
              end else if (dir_left_q) begin
                led_d = led_q << 1;
              end else begin
                led_d = led_q >> 1;
              end
            end
            M_FILL: led_d = (&led_q) ? '0 : {1'b1, led_q[N_LED-1:1]};
            default: led_d = led_q;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          led_d   = '0;
          cnt_d   = CW'(1);
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign led       = led_q;
  assign step_tick = tick_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Directed bench for led_shift_sequencer with TICK_DIV=8, N_LED=8; expected
// LED sequences are hand-written tables indexed by elapsed step count.
module tb_led_shift_sequencer;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       start  = 1'b0;
  logic       pause  = 1'b0;
  logic       stop   = 1'b0;
  logic [1:0] mode   = 2'b00;
  logic [1:0] speed  = 2'b00;
  logic [7:0] led;
  logic       step_tick;
  logic       busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] ror_seq    [9]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] bounce_seq [16] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                  8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
  logic [7:0] fill_seq   [11] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                                  8'hFF, 8'h00, 8'h80};

  led_shift_sequencer #(
    .TICK_DIV (8),
    .N_LED    (8),
    .CW       (26)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .mode      (mode),
    .speed     (speed),
    .led       (led),
    .step_tick (step_tick),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step_clk(input int unsigned n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [1:0] s, input logic [7:0] init);
    mode  = m;
    speed = s;
    start = 1'b1;
    step_clk(1);
    start = 1'b0;
    check("start_led", led, init);
    check("start_busy", busy, 1);
    check("start_tick", step_tick, 0);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step_clk(1);
    stop = 1'b0;
    check("stop_led", led, 0);
    check("stop_busy", busy, 0);
  endtask

  initial begin
    // power-on reset
    step_clk(2);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", step_tick, 0);
    rst = 1'b0;
    step_clk(2);

    // asynchronous reset in the middle of a run
    do_start(2'b00, 2'b00, 8'h80);
    step_clk(10);
    check("pre_rst_led", led, 8'h40);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", led, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_tick", step_tick, 0);
    rst = 1'b0;
    for (int unsigned k = 0; k < 20; k++) begin
      step_clk(1);
      check("post_rst_led", led, 0);
      check("post_rst_tick", step_tick, 0);
    end

    // rotate right, speed 0 (8-cycle steps), including the 01 -> 80 wrap
    do_start(2'b00, 2'b00, 8'h80);
    for (int unsigned k = 1; k <= 64; k++) begin
      step_clk(1);
      check("ror_led", led, ror_seq[k/8]);
      check("ror_tick", step_tick, (k % 8) == 0);
    end
    do_stop();

    // bounce, speed 1 (4-cycle steps); ends held for one step only
    do_start(2'b10, 2'b01, 8'h80);
    for (int unsigned k = 1; k <= 60; k++) begin
      step_clk(1);
      check("bounce_led", led, bounce_seq[k/4]);
      check("bounce_tick", step_tick, (k % 4) == 0);
    end
    do_stop();

    // fill-right, speed 0, wraps from FF to 00
    do_start(2'b11, 2'b00, 8'h00);
    for (int unsigned k = 1; k <= 80; k++) begin
      step_clk(1);
      check("fill_led", led, fill_seq[k/8]);
      check("fill_tick", step_tick, (k % 8) == 0);
    end
    do_stop();

    // rotate left with a 20-cycle pause once the counter has reached 5
    do_start(2'b01, 2'b00, 8'h01);
    step_clk(4);
    pause = 1'b1;
    mode  = 2'b00;
    for (int unsigned k = 0; k < 20; k++) begin
      step_clk(1);
      check("pause_led", led, 8'h01);
      check("pause_tick", step_tick, 0);
      check("pause_busy", busy, 1);
    end
    pause = 1'b0;
    // resume edge holds the count at 5, then 6, 7, 8, then the step
    for (int unsigned k = 1; k <= 4; k++) begin
      step_clk(1);
      check("resume_led", led, 8'h01);
      check("resume_tick", step_tick, 0);
    end
    step_clk(1);
    check("resume_step_led", led, 8'h02);
    check("resume_step_tick", step_tick, 1);

    // counter at 6, then speed 3: immediate step, then a step every cycle
    step_clk(5);
    check("pre_speed_led", led, 8'h02);
    speed = 2'b11;
    step_clk(1);
    check("speed_led0", led, 8'h04);
    check("speed_tick0", step_tick, 1);
    step_clk(1);
    check("speed_led1", led, 8'h08);
    check("speed_tick1", step_tick, 1);
    start = 1'b1;
    mode  = 2'b11;
    step_clk(1);
    start = 1'b0;
    check("ign_start_led", led, 8'h10);
    check("ign_start_tick", step_tick, 1);
    check("ign_start_busy", busy, 1);
    step_clk(1);
    check("speed_led3", led, 8'h20);

    // stop coincident with a step: step suppressed, idle next cycle
    stop = 1'b1;
    step_clk(1);
    stop = 1'b0;
    check("stop_step_led", led, 0);
    check("stop_step_tick", step_tick, 0);
    check("stop_step_busy", busy, 0);
    step_clk(3);
    check("idle_led", led, 0);
    check("idle_tick", step_tick, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
